// File: rtl/swervolf_ram_loader_if.sv
// Image-stream and RAM AXI4 write-channel bundle for the boot loader.
// master = loader side, slave = stream source / interconnect side.
interface swervolf_ram_loader_if #(
    parameter int ID_WIDTH = 8
);
    logic [7:0]          i_data;
    logic                i_valid;
    logic                o_ready;

    logic [ID_WIDTH-1:0] o_awid;
    logic [31:0]         o_awaddr;
    logic [7:0]          o_awlen;
    logic [2:0]          o_awsize;
    logic [1:0]          o_awburst;
    logic                o_awvalid;
    logic                i_awready;

    logic [63:0]         o_wdata;
    logic [7:0]          o_wstrb;
    logic                o_wlast;
    logic                o_wvalid;
    logic                i_wready;

    logic [ID_WIDTH-1:0] i_bid;
    logic [1:0]          i_bresp;
    logic                i_bvalid;
    logic                o_bready;

    modport master (
        input  i_data, i_valid, i_awready, i_wready, i_bid, i_bresp, i_bvalid,
        output o_ready, o_awid, o_awaddr, o_awlen, o_awsize, o_awburst, o_awvalid,
               o_wdata, o_wstrb, o_wlast, o_wvalid, o_bready
    );

    modport slave (
        output i_data, i_valid, i_awready, i_wready, i_bid, i_bresp, i_bvalid,
        input  o_ready, o_awid, o_awaddr, o_awlen, o_awsize, o_awburst, o_awvalid,
               o_wdata, o_wstrb, o_wlast, o_wvalid, o_bready
    );
endinterface

// File: rtl/swervolf_ram_loader.sv
// Boot loader: length-prefixed byte stream -> single-beat 64-bit AXI4 writes, core held in reset until committed.
// SWERVOLF_LOADER_CHECKSUM_EN adds a trailing 32-bit byte-sum check before release.
module swervolf_ram_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] MAX_BYTES = 32'h0001_0000,
    parameter int          ID_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    swervolf_ram_loader_if.master bus,
    output logic                  o_core_rst,
    output logic                  o_done,
    output logic                  o_err
);

`ifdef SWERVOLF_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_LEN, S_DATA, S_XFER, S_RESP, S_DONE, S_ERR, S_CSUM} state_t;
`else
    typedef enum logic [2:0] {S_LEN, S_DATA, S_XFER, S_RESP, S_DONE, S_ERR} state_t;
`endif

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [23:0] shift_q, shift_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic [2:0]  lane_q, lane_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        ready_q, ready_d;
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
`endif

    logic [31:0] word_in;
    logic        byte_hs;
    logic        unused_bid;

    assign word_in    = {bus.i_data, shift_q};
    assign byte_hs    = bus.i_valid & ready_q;
    assign unused_bid = ^bus.i_bid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_LEN;
            cnt_q     <= 2'd0;
            shift_q   <= 24'd0;
            rem_q     <= 32'd0;
            addr_q    <= BASE_ADDR;
            wdata_q   <= 64'd0;
            wstrb_q   <= 8'd0;
            lane_q    <= 3'd0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            ready_q   <= 1'b0;
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
            sum_q     <= 32'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            rem_q     <= rem_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            lane_q    <= lane_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            ready_q   <= ready_d;
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        rem_d     = rem_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        lane_d    = lane_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
        sum_d     = sum_q;
`endif

        case (state_q)
            S_LEN: begin
                if (byte_hs) begin
                    shift_d = word_in[31:8];
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (word_in == 32'd0) begin
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
                            state_d = S_CSUM;
`else
                            state_d = S_DONE;
`endif
                        end else if (word_in > MAX_BYTES) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                            rem_d   = word_in;
                            addr_d  = BASE_ADDR;
                            lane_d  = 3'd0;
                            wdata_d = 64'd0;
                            wstrb_d = 8'd0;
                        end
                    end
                end
            end

            S_DATA: begin
                if (byte_hs) begin
                    wdata_d[{lane_q, 3'b000} +: 8] = bus.i_data;
                    wstrb_d[lane_q]                = 1'b1;
                    lane_d = lane_q + 3'd1;
                    rem_d  = rem_q - 32'd1;
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
                    sum_d  = sum_q + {24'd0, bus.i_data};
`endif
                    // rem_q is never 0 here, so the decrement cannot wrap
                    if (lane_q == 3'd7 || rem_q == 32'd1) begin
                        state_d   = S_XFER;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end
                end
            end

            S_XFER: begin
                if (awvalid_q && bus.i_awready) awvalid_d = 1'b0;
                if (wvalid_q && bus.i_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d)    state_d   = S_RESP;
            end

            S_RESP: begin
                if (bus.i_bvalid) begin
                    if (bus.i_bresp != 2'b00) begin
                        state_d = S_ERR;
                    end else if (rem_q == 32'd0) begin
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_DATA;
                        addr_d  = addr_q + 32'd8;
                        lane_d  = 3'd0;
                        wdata_d = 64'd0;
                        wstrb_d = 8'd0;
                    end
                end
            end

`ifdef SWERVOLF_LOADER_CHECKSUM_EN
            S_CSUM: begin
                // cnt_q has wrapped back to 0 after the length field
                if (byte_hs) begin
                    shift_d = word_in[31:8];
                    cnt_d   = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_d = (word_in == sum_q) ? S_DONE : S_ERR;
                end
            end
`endif

            default: ;
        endcase

`ifdef SWERVOLF_LOADER_CHECKSUM_EN
        ready_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
`else
        ready_d = (state_d == S_LEN) || (state_d == S_DATA);
`endif
    end

    assign bus.o_ready   = ready_q;
    assign bus.o_awid    = {ID_WIDTH{1'b0}};
    assign bus.o_awaddr  = addr_q;
    assign bus.o_awlen   = 8'd0;
    assign bus.o_awsize  = 3'd3;
    assign bus.o_awburst = 2'b01;
    assign bus.o_awvalid = awvalid_q;
    assign bus.o_wdata   = wdata_q;
    assign bus.o_wstrb   = wstrb_q;
    assign bus.o_wlast   = 1'b1;
    assign bus.o_wvalid  = wvalid_q;
    assign bus.o_bready  = (state_q == S_RESP);

    assign o_done     = (state_q == S_DONE);
    assign o_err      = (state_q == S_ERR);
    assign o_core_rst = (state_q != S_DONE);

endmodule

// File: tb/tb_swervolf_ram_loader.sv
// Directed bench for swervolf_ram_loader: vector table of images plus hand sequences for timing/reset corners.
module tb_swervolf_ram_loader;
    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam logic [31:0] MAXB = 32'h0001_0000;
    localparam int          BUDGET = 3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic core_rst, done, err;

    always #5 clk = ~clk;

    swervolf_ram_loader_if #(.ID_WIDTH(8)) bus ();

    swervolf_ram_loader #(.BASE_ADDR(BASE), .MAX_BYTES(MAXB), .ID_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_core_rst (core_rst),
        .o_done     (done),
        .o_err      (err)
    );

    typedef struct {
        string       name;
        logic [31:0] len;
        int          npay;
        logic [7:0]  pbase;
        logic [7:0]  pstep;
        logic [31:0] csum;
        int          bad_idx;
        int          aw_dly;
        int          w_dly;
        bit          gaps;
        int          exp_nwr;
        bit          exp_done;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [7:0]  s0;
        logic [7:0]  s1;
    } vec_t;

    vec_t vecs[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] w_addr[4];
    logic [63:0] w_data[4];
    logic [7:0]  w_strb[4];
    int naw, nw, nb, proto;
    bit tmo;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_data    = 8'd0;
        bus.i_valid   = 1'b0;
        bus.i_awready = 1'b0;
        bus.i_wready  = 1'b0;
        bus.i_bid     = 8'd0;
        bus.i_bresp   = 2'b00;
        bus.i_bvalid  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
        int w;
        ok = 1'b0;
        for (int g = 0; g < gap; g++) begin
            bus.i_valid = 1'b0;
            @(negedge clk);
        end
        bus.i_valid = 1'b1;
        bus.i_data  = b;
        w = 0;
        while (!bus.o_ready && !done && !err && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (w >= 400) tmo = 1'b1;
        if (bus.o_ready) begin
            @(negedge clk);
            ok = 1'b1;
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic drive_stream(input vec_t v);
        logic [7:0] bq[$];
        logic [7:0] x;
        bit ok;
        for (int i = 0; i < 4; i++) bq.push_back(v.len[8*i +: 8]);
        x = v.pbase;
        for (int i = 0; i < v.npay; i++) begin
            bq.push_back(x);
            x = x + v.pstep;
        end
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
        for (int i = 0; i < 4; i++) bq.push_back(v.csum[8*i +: 8]);
`endif
        foreach (bq[i]) begin
            if (done || err || tmo) break;
            send_byte(bq[i], v.gaps ? int'($urandom_range(3, 0)) : 0, ok);
            if (!ok) break;
        end
    endtask

    task automatic respond(input vec_t v);
        int k, aw_cnt, w_cnt;
        bit aw_hs, w_hs;
        logic [31:0] l_addr;
        logic [63:0] l_data;
        logic [7:0]  l_strb;
        aw_cnt = 0; w_cnt = 0; aw_hs = 0; w_hs = 0;
        l_addr = '0; l_data = '0; l_strb = '0;
        for (k = 0; k < BUDGET; k++) begin
            @(negedge clk);
            bus.i_awready = 1'b0;
            bus.i_wready  = 1'b0;
            bus.i_bvalid  = 1'b0;
            bus.i_bresp   = 2'b00;
            if (done || err) break;
            if (bus.o_bready && !(aw_hs && w_hs)) proto++;
            if (bus.o_awvalid && aw_hs) proto++;
            if (bus.o_wvalid && w_hs) proto++;
            if (bus.o_awvalid && !aw_hs) begin
                if (aw_cnt > 0 && bus.o_awaddr !== l_addr) proto++;
                l_addr = bus.o_awaddr;
                if (aw_cnt >= v.aw_dly) begin
                    bus.i_awready = 1'b1;
                    aw_hs = 1'b1;
                    if (naw < 4) w_addr[naw] = bus.o_awaddr;
                    naw++;
                end
                aw_cnt++;
            end
            if (bus.o_wvalid && !w_hs) begin
                if (w_cnt > 0 && (bus.o_wdata !== l_data || bus.o_wstrb !== l_strb)) proto++;
                l_data = bus.o_wdata;
                l_strb = bus.o_wstrb;
                if (w_cnt >= v.w_dly) begin
                    bus.i_wready = 1'b1;
                    w_hs = 1'b1;
                    if (nw < 4) begin
                        w_data[nw] = bus.o_wdata;
                        w_strb[nw] = bus.o_wstrb;
                    end
                    nw++;
                end
                w_cnt++;
            end else if (bus.o_bready && aw_hs && w_hs) begin
                bus.i_bvalid = 1'b1;
                bus.i_bresp  = (nb == v.bad_idx) ? 2'b10 : 2'b00;
                nb++;
                aw_hs = 0; w_hs = 0; aw_cnt = 0; w_cnt = 0;
            end
        end
        if (k >= BUDGET) tmo = 1'b1;
        bus.i_awready = 1'b0;
        bus.i_wready  = 1'b0;
        bus.i_bvalid  = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        do_reset();
        naw = 0; nw = 0; nb = 0; proto = 0; tmo = 1'b0;
        fork
            drive_stream(v);
            respond(v);
        join
        @(negedge clk);
        check({v.name, ".timeout"}, 64'(tmo), 64'd0);
        check({v.name, ".done"}, 64'(done), 64'(v.exp_done));
        check({v.name, ".err"}, 64'(err), 64'(!v.exp_done));
        check({v.name, ".core_rst"}, 64'(core_rst), 64'(!v.exp_done));
        check({v.name, ".ready_off"}, 64'(bus.o_ready), 64'd0);
        check({v.name, ".aw_count"}, 64'(naw), 64'(v.exp_nwr));
        check({v.name, ".w_count"}, 64'(nw), 64'(v.exp_nwr));
        check({v.name, ".protocol"}, 64'(proto), 64'd0);
        if (v.exp_nwr > 0 && naw > 0 && nw > 0) begin
            check({v.name, ".addr0"}, 64'(w_addr[0]), 64'(BASE));
            check({v.name, ".data0"}, w_data[0], v.d0);
            check({v.name, ".strb0"}, 64'(w_strb[0]), 64'(v.s0));
        end
        if (v.exp_nwr > 1 && naw > 1 && nw > 1) begin
            check({v.name, ".addr1"}, 64'(w_addr[1]), 64'(BASE + 32'd8));
            check({v.name, ".data1"}, w_data[1], v.d1);
            check({v.name, ".strb1"}, 64'(w_strb[1]), 64'(v.s1));
        end
    endtask

    initial begin
        bit ok;
        //                 name      len            npay base   step   csum    bad aw w  gap nwr done d0                     d1                     s0     s1
        vecs.push_back('{"inc16",   32'd16,        16, 8'h00, 8'h01, 32'h78,  -1, 0, 0, 0,  2, 1, 64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 8'hFF, 8'hFF});
        vecs.push_back('{"part3",   32'd3,         3,  8'hAA, 8'h11, 32'h231, -1, 0, 0, 0,  1, 1, 64'h0000000000CCBBAA, 64'h0,                8'h07, 8'h00});
        vecs.push_back('{"zero",    32'd0,         0,  8'h00, 8'h00, 32'h0,   -1, 0, 0, 0,  0, 1, 64'h0,                64'h0,                8'h00, 8'h00});
        vecs.push_back('{"toolong", 32'h00010001,  0,  8'h00, 8'h00, 32'h0,   -1, 0, 0, 0,  0, 0, 64'h0,                64'h0,                8'h00, 8'h00});
        vecs.push_back('{"slverr",  32'd8,         8,  8'h11, 8'h01, 32'hA4,   0, 0, 0, 0,  1, 0, 64'h1817161514131211, 64'h0,                8'hFF, 8'h00});
        vecs.push_back('{"aw_slow", 32'd8,         8,  8'h11, 8'h01, 32'hA4,  -1, 5, 0, 0,  1, 1, 64'h1817161514131211, 64'h0,                8'hFF, 8'h00});
        vecs.push_back('{"w_slow",  32'd8,         8,  8'h11, 8'h01, 32'hA4,  -1, 0, 5, 0,  1, 1, 64'h1817161514131211, 64'h0,                8'hFF, 8'h00});
        vecs.push_back('{"gaps16",  32'd16,        16, 8'h00, 8'h01, 32'h78,  -1, 0, 0, 1,  2, 1, 64'h0706050403020100, 64'h0F0E0D0C0B0A0908, 8'hFF, 8'hFF});
        vecs.push_back('{"gaps10",  32'd10,        10, 8'h00, 8'h01, 32'h2D,  -1, 2, 1, 1,  2, 1, 64'h0706050403020100, 64'h0000000000000908, 8'hFF, 8'h03});
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
        vecs.push_back('{"csum_ok", 32'd2,         2,  8'h01, 8'h01, 32'h3,   -1, 0, 0, 0,  1, 1, 64'h0000000000000201, 64'h0,                8'h03, 8'h00});
        vecs.push_back('{"csum_bad",32'd2,         2,  8'h01, 8'h01, 32'h4,   -1, 0, 0, 0,  1, 0, 64'h0000000000000201, 64'h0,                8'h03, 8'h00});
`endif

        // Reset values while rst is held
        idle_inputs();
        repeat (2) @(negedge clk);
        check("rst.ready", 64'(bus.o_ready), 64'd0);
        check("rst.awvalid", 64'(bus.o_awvalid), 64'd0);
        check("rst.wvalid", 64'(bus.o_wvalid), 64'd0);
        check("rst.bready", 64'(bus.o_bready), 64'd0);
        check("rst.awaddr", 64'(bus.o_awaddr), 64'(BASE));
        check("rst.wdata", bus.o_wdata, 64'd0);
        check("rst.wstrb", 64'(bus.o_wstrb), 64'd0);
        check("rst.core_rst", 64'(core_rst), 64'd1);
        check("rst.done", 64'(done), 64'd0);
        check("rst.err", 64'(err), 64'd0);
        check("const.aw", {32'd0, 8'(bus.o_awid), bus.o_awlen, 5'd0, bus.o_awsize, 6'd0, bus.o_awburst},
              {32'd0, 8'h00, 8'h00, 5'd0, 3'd3, 6'd0, 2'b01});
        check("const.wlast", 64'(bus.o_wlast), 64'd1);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Zero-length image: done appears right after the 4th length byte, stream stays closed
        do_reset();
        tmo = 1'b0;
        for (int i = 0; i < 3; i++) send_byte(8'h00, 0, ok);
        check("l0.done_early", 64'(done), 64'd0);
        send_byte(8'h00, 0, ok);
`ifdef SWERVOLF_LOADER_CHECKSUM_EN
        check("l0.csum_wait", 64'(done), 64'd0);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 0, ok);
`endif
        check("l0.done", 64'(done), 64'd1);
        check("l0.core_rst", 64'(core_rst), 64'd0);
        bus.i_valid = 1'b1;
        bus.i_data  = 8'h5A;
        repeat (3) @(negedge clk);
        check("l0.ready_closed", 64'(bus.o_ready), 64'd0);
        check("l0.no_aw", 64'(bus.o_awvalid), 64'd0);
        bus.i_valid = 1'b0;

        // Asynchronous abort with a write pending on both channels
        do_reset();
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'd8 : 8'd0, 0, ok);
        for (int i = 0; i < 8; i++) send_byte(8'(i), 0, ok);
        check("abort.awvalid_pre", 64'(bus.o_awvalid), 64'd1);
        check("abort.wvalid_pre", 64'(bus.o_wvalid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("abort.awvalid", 64'(bus.o_awvalid), 64'd0);
        check("abort.wvalid", 64'(bus.o_wvalid), 64'd0);
        check("abort.ready", 64'(bus.o_ready), 64'd0);
        check("abort.timeout", 64'(tmo), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
